reg_mem_pipe: RTL and testbench
===============================

// Module: reg_mem_pipe
// PURPOSE
//  Parametrised MEM/WB pipeline register with valid/ready flow control, flush and an optional
//  2-entry skid buffer. Sits between the data-memory stage and register-file write-back.
//  Inserts bubbles cleanly, stalls without losing data, and never issues a spurious register write.
// PARAMETERS
//  DATA_W  32  width of alu_out / dmem_rdata
//  REG_AW  5   width of rfile_wn (destination register number)
//  SKID    1   1 = 2-entry skid buffer (in_ready registered); 0 = single entry (in_ready combinational)
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous, active-high reset
//  flush           in   1       kill all held entries (branch/exception squash)
//  in_valid        in   1       upstream MEM stage has a valid instruction
//  in_ready        out  1       stage can accept this cycle
//  MemtoReg        in   1       select dmem_rdata (1) or alu_out (0) at WB
//  RegWrite        in   1       instruction writes the register file
//  dmem_rdata      in   DATA_W  load data
//  alu_out         in   DATA_W  ALU result / address
//  rfile_wn        in   REG_AW  destination register
//  out_valid       out  1       head entry is valid
//  out_ready       in   1       WB consumes the head entry this cycle
//  out_MemtoReg    out  1       head MemtoReg
//  out_RegWrite    out  1       RegWrite & out_valid & (out_rfile_wn != 0)
//  out_dmem_rdata  out  DATA_W  head load data
//  out_alu_out     out  DATA_W  head ALU result
//  out_rfile_wn    out  REG_AW  head destination register
//  occupancy       out  2       entries held: 0,1,2 (max 1 when SKID=0)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency: in_fire at cycle N
//    -> out_valid with that data at cycle N+1. Entries leave strictly in arrival order.
//  - Reset (rst=1 at posedge): both entries invalid, all stored fields 0, occupancy=0,
//    out_valid=0, out_RegWrite=0; in_ready=1 from the first cycle after reset.
//  - rst has priority over flush; flush has priority over any transfer.
//  - flush=1 at posedge: state -> EMPTY, occupancy=0; in_fire/out_fire that cycle are ignored
//    (input dropped, head not counted as consumed); stored data fields hold, only valids clear.
//  - SKID=1 FSM (head H, skid S):
//      EMPTY: in_ready=1; in_fire -> H<=in, ONE.
//      ONE:   in_ready=1; in_fire&out_fire -> H<=in, ONE; in_fire&!out_fire -> S<=in, FULL;
//             !in_fire&out_fire -> EMPTY; none -> hold.
//      FULL:  in_ready=0; out_fire -> H<=S, ONE; else hold. Incoming data never overwrites S.
//    in_ready is a pure register output (no out_ready -> in_ready combinational path).
//  - SKID=0: single entry H; in_ready = !H_valid | out_ready (combinational);
//    in_fire -> H<=in; out_fire & !in_fire -> H invalid.
//  - Outputs are driven from H only; while out_valid=0, data outputs show last stored H value
//    (0 after reset) and out_RegWrite=0.
//  - out_RegWrite suppressed for rfile_wn==0 (writes to $zero never issued).
//  - Held entries are fully stable while out_valid=1 and out_ready=0.
// TESTING
//  1 Reset: rst=1 two cycles -> out_valid=0, out_RegWrite=0, occupancy=0, in_ready=1, data=0.
//  2 Stream: out_ready=1, push alu_out=0x10,0x20,0x30 on consecutive cycles, RegWrite=1, wn=5
//    -> out_valid cycles N+1..N+3 with same values in order, occupancy stays 1.
//  3 Stall (SKID=1): push A=0xAAAA, B=0xBBBB with out_ready=0 -> occupancy=2, in_ready=0,
//    head=A held stable; C presented is not taken; raise out_ready -> A, B, then C accepted.
//  4 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0,
//    input dropped; next push appears 1 cycle later normally.
//  5 $zero guard: push RegWrite=1, rfile_wn=0, alu_out=0x1234 -> out_valid=1, out_RegWrite=0.
//  6 Reset mid-operation: occupancy=2, rst=1 and flush=1 together -> fields 0, occupancy=0;
//    repeat 2-3 with SKID=0 and check in_ready tracks out_ready combinationally.

Source files
------------

// File: rtl/reg_mem_pipe.sv
// MEM/WB pipeline register with valid/ready handshake, flush and an optional
// 2-entry skid buffer. Outputs always come from the head entry.
module reg_mem_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              MemtoReg,
   input  logic              RegWrite,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [REG_AW-1:0] rfile_wn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_MemtoReg,
   output logic              out_RegWrite,
   output logic [DATA_W-1:0] out_dmem_rdata,
   output logic [DATA_W-1:0] out_alu_out,
   output logic [REG_AW-1:0] out_rfile_wn,
   output logic [1:0]        occupancy
);

   localparam int EW = 2 + 2 * DATA_W + REG_AW;

   logic [EW-1:0] in_ent;
   logic [EW-1:0] hd_p0;
   logic          hd_vld_p0;
   logic          hd_regwrite;
   logic          in_fire;
   logic          out_fire;

   assign in_ent   = {MemtoReg, RegWrite, dmem_rdata, alu_out, rfile_wn};
   assign in_fire  = in_valid & in_ready;
   assign out_fire = hd_vld_p0 & out_ready;

   // WB side: everything visible downstream is decoded from the head entry
   assign {out_MemtoReg, hd_regwrite, out_dmem_rdata, out_alu_out, out_rfile_wn} = hd_p0;
   assign out_valid    = hd_vld_p0;
   assign out_RegWrite = hd_regwrite & hd_vld_p0 & (out_rfile_wn != '0);

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

         state_t        state_q, state_d;
         logic          rdy_q;
         logic [EW-1:0] sk_p0;
         logic          ld_hd_in, ld_sk_in, ld_hd_sk;

         always_comb begin
            state_d  = state_q;
            ld_hd_in = 1'b0;
            ld_sk_in = 1'b0;
            ld_hd_sk = 1'b0;
            if (flush) begin
               state_d = EMPTY;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (in_fire) begin
                        ld_hd_in = 1'b1;
                        state_d  = ONE;
                     end
                  end
                  ONE: begin
                     if (in_fire && out_fire) begin
                        ld_hd_in = 1'b1;
                     end else if (in_fire) begin
                        ld_sk_in = 1'b1;
                        state_d  = FULL;
                     end else if (out_fire) begin
                        state_d  = EMPTY;
                     end
                  end
                  FULL: begin
                     if (out_fire) begin
                        ld_hd_sk = 1'b1;
                        state_d  = ONE;
                     end
                  end
                  default: state_d = EMPTY;
               endcase
            end
         end

         // in_ready is registered from the next state so out_ready never reaches it
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= EMPTY;
               rdy_q   <= 1'b1;
               hd_p0   <= '0;
               sk_p0   <= '0;
            end else begin
               state_q <= state_d;
               rdy_q   <= (state_d != FULL);
               if (ld_hd_in) hd_p0 <= in_ent;
               if (ld_hd_sk) hd_p0 <= sk_p0;
               if (ld_sk_in) sk_p0 <= in_ent;
            end
         end

         assign in_ready  = rdy_q;
         assign hd_vld_p0 = (state_q != EMPTY);

         always_comb begin
            occupancy = 2'd0;
            case (state_q)
               ONE:     occupancy = 2'd1;
               FULL:    occupancy = 2'd2;
               default: occupancy = 2'd0;
            endcase
         end
      end else begin : g_single
         logic vld_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
               hd_p0 <= '0;
            end else if (flush) begin
               vld_q <= 1'b0;
            end else if (in_fire) begin
               vld_q <= 1'b1;
               hd_p0 <= in_ent;
            end else if (out_fire) begin
               vld_q <= 1'b0;
            end
         end

         assign in_ready  = ~vld_q | out_ready;
         assign hd_vld_p0 = vld_q;
         assign occupancy = {1'b0, vld_q};
      end
   endgenerate

endmodule

// File: tb/tb_reg_mem_pipe.sv
// Bench for reg_mem_pipe: a SKID=1 and a SKID=0 instance share stimulus and are
// each compared against a queue-based model of an in-order buffer.
module tb_reg_mem_pipe;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int EW = 2 + 2 * DW + AW;

   typedef struct packed {
      logic          mtr;
      logic          rw;
      logic [DW-1:0] rd;
      logic [DW-1:0] alu;
      logic [AW-1:0] wn;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic          MemtoReg = 1'b0, RegWrite = 1'b0;
   logic [DW-1:0] dmem_rdata = '0, alu_out = '0;
   logic [AW-1:0] rfile_wn = '0;

   logic          ir_a, ov_a, om_a, orw_a, ir_b, ov_b, om_b, orw_b;
   logic [DW-1:0] ord_a, oal_a, ord_b, oal_b;
   logic [AW-1:0] own_a, own_b;
   logic [1:0]    occ_a, occ_b;

   reg_mem_pipe #(.DATA_W(DW), .REG_AW(AW), .SKID(1)) dut_skid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .dmem_rdata(dmem_rdata),
      .alu_out(alu_out), .rfile_wn(rfile_wn), .out_valid(ov_a), .out_ready(out_ready),
      .out_MemtoReg(om_a), .out_RegWrite(orw_a), .out_dmem_rdata(ord_a),
      .out_alu_out(oal_a), .out_rfile_wn(own_a), .occupancy(occ_a));

   reg_mem_pipe #(.DATA_W(DW), .REG_AW(AW), .SKID(0)) dut_single (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .dmem_rdata(dmem_rdata),
      .alu_out(alu_out), .rfile_wn(rfile_wn), .out_valid(ov_b), .out_ready(out_ready),
      .out_MemtoReg(om_b), .out_RegWrite(orw_b), .out_dmem_rdata(ord_b),
      .out_alu_out(oal_b), .out_rfile_wn(own_b), .occupancy(occ_b));

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   ent_t qa[$];
   ent_t qb[$];
   ent_t ha = '0;
   ent_t hb = '0;

   function automatic logic rdy_a();
      return qa.size() < 2;
   endfunction

   function automatic logic rdy_b();
      return (qb.size() == 0) || out_ready;
   endfunction

   function automatic ent_t mk(logic mtr, logic rw, logic [DW-1:0] rd,
                               logic [DW-1:0] alu, logic [AW-1:0] wn);
      ent_t e;
      e.mtr = mtr; e.rw = rw; e.rd = rd; e.alu = alu; e.wn = wn;
      return e;
   endfunction

   task automatic chk(string tag, logic [EW-1:0] obs, logic [EW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string ph);
      logic va, vb;
      va = qa.size() > 0;
      vb = qb.size() > 0;
      chk({ph, ":skid.in_ready"},   EW'(ir_a),  EW'(rdy_a()));
      chk({ph, ":skid.out_valid"},  EW'(ov_a),  EW'(va));
      chk({ph, ":skid.occupancy"},  EW'(occ_a), EW'(qa.size()));
      chk({ph, ":skid.head"},       EW'({om_a, ord_a, oal_a, own_a}),
          EW'({ha.mtr, ha.rd, ha.alu, ha.wn}));
      chk({ph, ":skid.RegWrite"},   EW'(orw_a), EW'(va && ha.rw && (ha.wn != 0)));
      chk({ph, ":single.in_ready"}, EW'(ir_b),  EW'(rdy_b()));
      chk({ph, ":single.out_valid"},EW'(ov_b),  EW'(vb));
      chk({ph, ":single.occupancy"},EW'(occ_b), EW'(qb.size()));
      chk({ph, ":single.head"},     EW'({om_b, ord_b, oal_b, own_b}),
          EW'({hb.mtr, hb.rd, hb.alu, hb.wn}));
      chk({ph, ":single.RegWrite"}, EW'(orw_b), EW'(vb && hb.rw && (hb.wn != 0)));
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic step(string ph, logic iv, ent_t e, logic ordy, logic fl, logic rs);
      logic ia, oa, ib, ob;
      in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
      {MemtoReg, RegWrite, dmem_rdata, alu_out, rfile_wn} = e;
      #1;
      check_all(ph);
      ia = iv && rdy_a();
      oa = (qa.size() > 0) && ordy;
      ib = iv && rdy_b();
      ob = (qb.size() > 0) && ordy;
      @(posedge clk);
      if (rs) begin
         qa.delete(); qb.delete(); ha = '0; hb = '0;
      end else if (fl) begin
         qa.delete(); qb.delete();
      end else begin
         if (oa) void'(qa.pop_front());
         if (ia) qa.push_back(e);
         if (qa.size() > 0) ha = qa[0];
         if (ob) void'(qb.pop_front());
         if (ib) qb.push_back(e);
         if (qb.size() > 0) hb = qb[0];
      end
      #1;
   endtask

   initial begin
      ent_t z;
      z = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      step("reset", 1'b0, z, 1'b0, 1'b0, 1'b0);

      step("stream0", 1'b1, mk(1'b0, 1'b1, 32'h0, 32'h10, 5'd5), 1'b1, 1'b0, 1'b0);
      step("stream1", 1'b1, mk(1'b0, 1'b1, 32'h0, 32'h20, 5'd5), 1'b1, 1'b0, 1'b0);
      step("stream2", 1'b1, mk(1'b0, 1'b1, 32'h0, 32'h30, 5'd5), 1'b1, 1'b0, 1'b0);
      step("stream3", 1'b0, z, 1'b1, 1'b0, 1'b0);
      step("stream4", 1'b0, z, 1'b1, 1'b0, 1'b0);

      step("stallA", 1'b1, mk(1'b1, 1'b1, 32'h5, 32'hAAAA, 5'd7), 1'b0, 1'b0, 1'b0);
      step("stallB", 1'b1, mk(1'b0, 1'b1, 32'h6, 32'hBBBB, 5'd8), 1'b0, 1'b0, 1'b0);
      step("stallC0", 1'b1, mk(1'b0, 1'b1, 32'h7, 32'hCCCC, 5'd9), 1'b0, 1'b0, 1'b0);
      step("stallC1", 1'b1, mk(1'b0, 1'b1, 32'h7, 32'hCCCC, 5'd9), 1'b0, 1'b0, 1'b0);
      step("drain0", 1'b1, mk(1'b0, 1'b1, 32'h7, 32'hCCCC, 5'd9), 1'b1, 1'b0, 1'b0);
      step("drain1", 1'b1, mk(1'b0, 1'b1, 32'h7, 32'hCCCC, 5'd9), 1'b1, 1'b0, 1'b0);
      step("drain2", 1'b0, z, 1'b1, 1'b0, 1'b0);
      step("drain3", 1'b0, z, 1'b1, 1'b0, 1'b0);

      step("fill0", 1'b1, mk(1'b0, 1'b1, 32'h1, 32'h111, 5'd3), 1'b0, 1'b0, 1'b0);
      step("fill1", 1'b1, mk(1'b0, 1'b1, 32'h2, 32'h222, 5'd4), 1'b0, 1'b0, 1'b0);
      step("flush", 1'b1, mk(1'b0, 1'b1, 32'h3, 32'h333, 5'd6), 1'b1, 1'b1, 1'b0);
      step("postflush0", 1'b1, mk(1'b1, 1'b1, 32'h4, 32'h444, 5'd2), 1'b1, 1'b0, 1'b0);
      step("postflush1", 1'b0, z, 1'b1, 1'b0, 1'b0);

      step("zero0", 1'b1, mk(1'b0, 1'b1, 32'h0, 32'h1234, 5'd0), 1'b0, 1'b0, 1'b0);
      step("zero1", 1'b0, z, 1'b0, 1'b0, 1'b0);
      step("zero2", 1'b0, z, 1'b1, 1'b0, 1'b0);

      step("mid0", 1'b1, mk(1'b1, 1'b0, 32'h9, 32'h999, 5'd1), 1'b0, 1'b0, 1'b0);
      step("mid1", 1'b1, mk(1'b1, 1'b1, 32'h8, 32'h888, 5'd2), 1'b0, 1'b0, 1'b0);
      step("rstflush", 1'b1, mk(1'b1, 1'b1, 32'h7, 32'h777, 5'd3), 1'b1, 1'b1, 1'b1);
      step("afterrst", 1'b1, mk(1'b0, 1'b1, 32'h6, 32'h666, 5'd4), 1'b0, 1'b0, 1'b0);

      // Single-entry in_ready must follow out_ready within the same cycle.
      out_ready = 1'b0;
      #1;
      chk("comb:single.in_ready.lo", EW'(ir_b), EW'(rdy_b()));
      chk("comb:skid.in_ready.lo",   EW'(ir_a), EW'(rdy_a()));
      out_ready = 1'b1;
      #1;
      chk("comb:single.in_ready.hi", EW'(ir_b), EW'(rdy_b()));
      chk("comb:skid.in_ready.hi",   EW'(ir_a), EW'(rdy_a()));

      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom % 2),
              mk(1'($urandom % 2), 1'($urandom % 2), $urandom, $urandom, AW'($urandom % 4)),
              1'($urandom % 2), ($urandom % 25) == 0, ($urandom % 80) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
